// File: rtl/serial_add_if.sv
// Handshake/operand bundle for serial_add_seq.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full-adder slice reused over WIDTH cycles, LSB first.
// Optional signed-overflow output ovf when SERIAL_ADD_OVF_EN is defined.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    serial_add_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] areg_q, areg_d;
    logic [WIDTH-1:0] breg_q, breg_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             s_bit, c_next;
    logic [WIDTH:0]   sreg_ext;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        s_bit    = areg_q[0] ^ breg_q[0] ^ carry_q;
        c_next   = (areg_q[0] & breg_q[0]) | (carry_q & (areg_q[0] ^ breg_q[0]));
        // Concatenate then drop the LSB so the shift also works for WIDTH=1.
        sreg_ext = {s_bit, sreg_q};

        state_d = state_q;
        areg_d  = areg_q;
        breg_d  = breg_q;
        sreg_d  = sreg_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    areg_d  = bus.a;
                    breg_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                areg_d  = areg_q >> 1;
                breg_d  = breg_q >> 1;
                sreg_d  = sreg_ext[WIDTH:1];
                carry_d = c_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = sreg_ext[WIDTH:1];
                    cout_d  = c_next;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB on this final step
                    ovf_d   = carry_q ^ c_next;
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            areg_q  <= '0;
            breg_q  <= '0;
            sreg_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            areg_q  <= areg_d;
            breg_q  <= breg_d;
            sreg_q  <= sreg_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq: WIDTH=8 and WIDTH=1 instances.
// ovf is checked only when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_seq;
    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t q8[$];
    exp_t q1[$];
    logic [7:0] prev_sum;
    logic       prev_cout;

    serial_add_if #(.WIDTH(8)) bus8 ();
    serial_add_if #(.WIDTH(1)) bus1 ();

    serial_add_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_add_seq #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitors: pop the expected result whenever a done pulse is presented.
    always @(negedge clk) begin
        if (!rst && bus8.done === 1'b1) begin
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL w8_spurious_done: got=done expected=no_done at %0t", $time);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("w8_sum", {24'd0, bus8.sum}, {24'd0, e.sum});
                check("w8_cout", {31'd0, bus8.cout}, {31'd0, e.cout});
`ifdef SERIAL_ADD_OVF_EN
                check("w8_ovf", {31'd0, bus8.ovf}, {31'd0, e.ovf});
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus1.done === 1'b1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL w1_spurious_done: got=done expected=no_done at %0t", $time);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("w1_sum", {31'd0, bus1.sum}, {24'd0, e.sum});
                check("w1_cout", {31'd0, bus1.cout}, {31'd0, e.cout});
`ifdef SERIAL_ADD_OVF_EN
                check("w1_ovf", {31'd0, bus1.ovf}, {31'd0, e.ovf});
`endif
            end
        end
    end

    // One WIDTH=8 operation: checks busy window, held sum during RUN and done latency.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = cin;
        q8.push_back('{es, ec, eo});
        @(posedge clk); #1;
        check("busy_after_accept", {31'd0, bus8.busy}, 32'd1);
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = ~a;
        bus8.b     = ~b;
        bus8.cin   = ~cin;
        lat = 1;
        while (lat <= 20) begin
            @(posedge clk); #1;
            if (bus8.done === 1'b1) break;
            check("busy_run", {31'd0, bus8.busy}, 32'd1);
            check("sum_held_run", {24'd0, bus8.sum}, {24'd0, prev_sum});
            check("cout_held_run", {31'd0, bus8.cout}, {31'd0, prev_cout});
            lat++;
        end
        check("done_latency", lat, 32'd8);
        check("busy_in_done", {31'd0, bus8.busy}, 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, bus8.done}, 32'd0);
        prev_sum  = es;
        prev_cout = ec;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total     = 0;
        bad       = 0;
        prev_sum  = 8'h00;
        prev_cout = 1'b0;
        rst       = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus8.busy}, 32'd0);
        check("rst_done", {31'd0, bus8.done}, 32'd0);
        check("rst_sum", {24'd0, bus8.sum}, 32'd0);
        check("rst_cout", {31'd0, bus8.cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        // start held high; operands change at E2; re-accept expected at E10
        begin
            int dones;
            dones = 0;
            @(negedge clk);
            bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0;
            q8.push_back('{8'h30, 1'b0, 1'b0});
            @(posedge clk); #1;
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk); #1;
                if (bus8.done === 1'b1) dones++;
                if (k == 2) begin
                    bus8.a = 8'hFF; bus8.b = 8'hFF;
                    q8.push_back('{8'hFE, 1'b1, 1'b0});
                end
                if (k == 7) check("held_sum_prev", {24'd0, bus8.sum}, 32'h80);
                if (k == 8) check("held_done_e8", {31'd0, bus8.done}, 32'd1);
                if (k == 9) check("held_idle_e9", {30'd0, bus8.busy, bus8.done}, 32'd0);
                if (k == 10) check("held_accept_e10", {31'd0, bus8.busy}, 32'd1);
            end
            check("held_single_done", dones, 32'd1);
            @(negedge clk);
            bus8.start = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (bus8.done === 1'b1) break;
            end
            check("held_second_done", {31'd0, bus8.done}, 32'd1);
            @(posedge clk); #1;
            prev_sum = 8'hFE; prev_cout = 1'b1;
        end

        // asynchronous reset after E3 discards the operation
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, bus8.busy}, 32'd0);
        check("arst_sum", {24'd0, bus8.sum}, 32'd0);
        check("arst_cout", {31'd0, bus8.cout}, 32'd0);
        check("arst_done", {31'd0, bus8.done}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        prev_sum = 8'h00; prev_cout = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("arst_idle", {31'd0, bus8.busy}, 32'd0);
        run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // WIDTH=1: done one cycle after accept
        @(negedge clk);
        bus1.start = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1;
        q1.push_back('{8'h01, 1'b1, 1'b0});
        @(posedge clk); #1;
        check("w1_busy", {31'd0, bus1.busy}, 32'd1);
        @(negedge clk);
        bus1.start = 1'b0;
        @(posedge clk); #1;
        check("w1_done_latency", {31'd0, bus1.done}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        bus1.start = 1'b1; bus1.a = 1'b1; bus1.b = 1'b0; bus1.cin = 1'b0;
        q1.push_back('{8'h01, 1'b0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        @(posedge clk); #1;
        check("w1_done_latency2", {31'd0, bus1.done}, 32'd1);
        repeat (3) @(posedge clk);
        #1;

        check("q8_drained", q8.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
